// File: rtl/muldiv_seq_pkg.sv
// Shared types for the multi-cycle mul/divu/remu sequencer.
// Operation codes match the decoded funct bits presented on the op input.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int ITER_W        = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    MUL  = 2'b00,
    DIVU = 2'b01,
    REMU = 2'b10,
    RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the datapath and the muldiv sequencer.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             i_start;
  logic             i_abort;
  op_t              i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic             o_stall;
  logic [WIDTH-1:0] o_result;

  modport master (
    output i_start, i_abort, i_op, i_a, i_b,
    input  o_busy, o_done, o_stall, o_result
  );

  modport slave (
    input  i_start, i_abort, i_op, i_a, i_b,
    output o_busy, o_done, o_stall, o_result
  );

endinterface

// File: rtl/muldiv_seq_step.sv
// One shift-add multiply or restoring-divide iteration, purely combinational.
// i_opd is the multiplicand (mul) or divisor (div); i_sh is the multiplier or dividend/quotient.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_opd,
  input  logic [WIDTH-1:0] i_sh,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_opd,
  output logic [WIDTH-1:0] o_sh
);

  logic [WIDTH:0] w_shifted;
  logic           w_fits;

  always_comb begin
    w_shifted = {i_acc, i_sh[WIDTH-1]};
    w_fits    = (w_shifted >= {1'b0, i_opd});
    o_acc     = i_acc;
    o_opd     = i_opd;
    o_sh      = i_sh;
    case (i_op)
      MUL: begin
        o_acc = i_acc + (i_sh[0] ? i_opd : '0);
        o_opd = i_opd << 1;
        o_sh  = i_sh >> 1;
      end
      DIVU, REMU: begin
        // The partial remainder stays below the divisor, so the difference always fits WIDTH bits.
        o_acc = w_fits ? (w_shifted[WIDTH-1:0] - i_opd) : w_shifted[WIDTH-1:0];
        o_sh  = {i_sh[WIDTH-2:0], w_fits};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle mul/divu/remu engine: IDLE -> BUSY (WIDTH iterations) -> DONE.
// Stalls the core while in flight and pulses done with the result for one cycle.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);

  localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  op_t              r_op;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opd;
  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic [WIDTH-1:0] w_acc;
  logic [WIDTH-1:0] w_opd;
  logic [WIDTH-1:0] w_sh;
  logic [WIDTH-1:0] w_result;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_op  (r_op),
    .i_acc (r_acc),
    .i_opd (r_opd),
    .i_sh  (r_sh),
    .o_acc (w_acc),
    .o_opd (w_opd),
    .o_sh  (w_sh)
  );

  always_comb begin
    w_result = '0;
    case (r_op)
      MUL:     w_result = w_acc;
      DIVU:    w_result = w_sh;
      REMU:    w_result = w_acc;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_op     <= MUL;
      r_acc    <= '0;
      r_opd    <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_start && !bus.i_abort) begin
            r_op    <= bus.i_op;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_opd   <= (bus.i_op == MUL) ? bus.i_a : bus.i_b;
            r_sh    <= (bus.i_op == MUL) ? bus.i_b : bus.i_a;
            r_state <= BUSY;
            r_busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.i_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc <= w_acc;
            r_opd <= w_opd;
            r_sh  <= w_sh;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST) begin
              r_result <= w_result;
              r_state  <= DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The accept cycle must already stall, so stall looks at the live start input.
  assign bus.o_stall  = !reset &&
                        (((r_state == IDLE) && bus.i_start && !bus.i_abort) || (r_state == BUSY));
  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
  assign bus.o_result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: cycle-level reference model compared every cycle,
// plus directed literal cases for arithmetic corners, abort, reset and start held through DONE.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   checkEn = 1'b0;

  muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

  muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: cycles of busy remaining, a done flag and the architectural result.
  int          mRemaining = 0;
  bit          mDone      = 1'b0;
  logic [31:0] mResult    = '0;
  logic [31:0] mPending   = '0;

  function automatic logic [31:0] refCalc(op_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      MUL:     return a * b;
      DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REMU:    return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mRemaining <= 0;
      mDone      <= 1'b0;
      mResult    <= '0;
    end else if (mDone) begin
      mDone <= 1'b0;
    end else if (mRemaining > 0) begin
      if (bus.i_abort) begin
        mRemaining <= 0;
      end else begin
        mRemaining <= mRemaining - 1;
        if (mRemaining == 1) begin
          mDone   <= 1'b1;
          mResult <= mPending;
        end
      end
    end else if (bus.i_start && !bus.i_abort) begin
      mRemaining <= WIDTH;
      mPending   <= refCalc(bus.i_op, bus.i_a, bus.i_b);
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy",   32'(bus.o_busy), 32'(mRemaining > 0));
      checkOutput("done",   32'(bus.o_done), 32'(mDone));
      checkOutput("result", bus.o_result, mResult);
      checkOutput("stall",  32'(bus.o_stall),
                  32'(!reset && ((mRemaining == 0 && !mDone && bus.i_start && !bus.i_abort) ||
                                 mRemaining > 0)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits up to 100 cycles for done; lat counts cycles from the call.
  task automatic waitDone(input bit scramble, output logic [31:0] res, output int lat);
    res = '0;
    lat = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      tick();
      if (bus.o_done) begin
        res = bus.o_result;
        lat = cyc;
        break;
      end
      if (scramble) begin
        bus.i_start = ($urandom_range(0, 1) == 1);
        bus.i_op    = op_t'($urandom_range(0, 3));
        bus.i_a     = $urandom;
        bus.i_b     = $urandom;
      end
    end
    if (lat < 0) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Issues one operation from IDLE and returns in the next IDLE cycle.
  task automatic applyStimulus(op_t op, logic [31:0] a, logic [31:0] b,
                               output logic [31:0] res, output int lat);
    bus.i_start = 1'b1;
    bus.i_abort = 1'b0;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    waitDone(1'b1, res, lat);
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    tick();
  endtask

  typedef struct {
    string       name;
    op_t         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dirVecs[$];

  initial begin
    logic [31:0] res;
    int          lat;
    int          doneSeen;

    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_op    = MUL;
    bus.i_a     = '0;
    bus.i_b     = '0;

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkEn = 1'b1;

    checkOutput("reset_busy",   32'(bus.o_busy), 32'd0);
    checkOutput("reset_done",   32'(bus.o_done), 32'd0);
    checkOutput("reset_result", bus.o_result, 32'd0);

    checkOutput("ref_mul",   refCalc(MUL, 32'd7, 32'd6), 32'd42);
    checkOutput("ref_div0",  refCalc(DIVU, 32'd5, 32'd0), 32'hFFFF_FFFF);
    checkOutput("ref_rem0",  refCalc(REMU, 32'd5, 32'd0), 32'd5);
    checkOutput("ref_rsvd",  refCalc(RSVD, 32'd9, 32'd3), 32'd0);

    dirVecs.push_back('{"mul_7x6",     MUL,  32'd7,         32'd6,         32'd42});
    dirVecs.push_back('{"mul_ones",    MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
    dirVecs.push_back('{"mul_2p16",    MUL,  32'h0001_0000, 32'h0001_0000, 32'h0000_0000});
    dirVecs.push_back('{"rsvd",        RSVD, 32'd123,       32'd45,        32'h0000_0000});
    dirVecs.push_back('{"divu_100_7",  DIVU, 32'd100,       32'd7,         32'd14});
    dirVecs.push_back('{"remu_100_7",  REMU, 32'd100,       32'd7,         32'd2});
    dirVecs.push_back('{"divu_msb_1",  DIVU, 32'h8000_0000, 32'd1,         32'h8000_0000});
    dirVecs.push_back('{"divu_5_0",    DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF});
    dirVecs.push_back('{"remu_5_0",    REMU, 32'd5,         32'd0,         32'd5});

    foreach (dirVecs[i]) begin
      applyStimulus(dirVecs[i].op, dirVecs[i].a, dirVecs[i].b, res, lat);
      checkOutput(dirVecs[i].name, res, dirVecs[i].exp);
      checkOutput({dirVecs[i].name, "_lat"}, 32'(lat), 32'd33);
    end

    // Abort in BUSY cycle 10; a start in cycle 11 is blocked by abort, cycle 12 is accepted.
    doneSeen    = 0;
    bus.i_start = 1'b1;
    bus.i_op    = DIVU;
    bus.i_a     = 32'd1000;
    bus.i_b     = 32'd3;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      bus.i_start = 1'b0;
      if (bus.o_done) doneSeen++;
    end
    bus.i_abort = 1'b1;
    tick();
    bus.i_start = 1'b1;
    bus.i_op    = MUL;
    bus.i_a     = 32'd3;
    bus.i_b     = 32'd5;
    checkOutput("abort_idle_busy", 32'(bus.o_busy), 32'd0);
    checkOutput("abort_no_done",   32'(bus.o_done || doneSeen != 0), 32'd0);
    checkOutput("abort_keeps_res", bus.o_result, 32'd5);
    tick();
    bus.i_abort = 1'b0;
    checkOutput("abort_blocks_start", 32'(bus.o_busy), 32'd0);
    tick();
    bus.i_start = 1'b0;
    checkOutput("post_abort_accept", 32'(bus.o_busy), 32'd1);
    waitDone(1'b0, res, lat);
    checkOutput("post_abort_result", res, 32'd15);
    tick();

    // Reset in the middle of BUSY clears outputs without waiting for a clock edge.
    bus.i_start = 1'b1;
    bus.i_op    = MUL;
    bus.i_a     = 32'd123;
    bus.i_b     = 32'd456;
    tick();
    bus.i_start = 1'b0;
    repeat (14) tick();
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_async_busy",   32'(bus.o_busy), 32'd0);
    checkOutput("rst_async_stall",  32'(bus.o_stall), 32'd0);
    checkOutput("rst_async_result", bus.o_result, 32'd0);
    tick();
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    checkOutput("rst_stays_idle", 32'(bus.o_busy | bus.o_done), 32'd0);

    // Start held through DONE: no restart in DONE, next accept in the following IDLE cycle.
    bus.i_start = 1'b1;
    bus.i_op    = MUL;
    bus.i_a     = 32'd9;
    bus.i_b     = 32'd9;
    waitDone(1'b0, res, lat);
    checkOutput("held_result", res, 32'd81);
    checkOutput("held_lat",    32'(lat), 32'd33);
    tick();
    checkOutput("held_idle_after_done", 32'(bus.o_busy), 32'd0);
    tick();
    bus.i_start = 1'b0;
    checkOutput("held_reaccept", 32'(bus.o_busy), 32'd1);
    waitDone(1'b0, res, lat);
    checkOutput("held_second_result", res, 32'd81);
    tick();

    for (int n = 0; n < 150; n++) begin
      op_t         op;
      logic [31:0] a;
      logic [31:0] b;
      op = op_t'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      applyStimulus(op, a, b, res, lat);
      checkOutput("rand_result", res, refCalc(op, a, b));
      repeat ($urandom_range(0, 2)) tick();
    end

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the core's M-extension subset: `mul` (low 32 bits), `divu` and `remu`. It replaces the combinational `*`, `/` and `%` paths in the ALU with a 32-iteration shift-add / restoring-divide engine. It sits beside the ALU in `datapath`. While an operation is in flight it asserts `stall` to `controller`, which freezes the PC register and register-file write. The result is injected into the result mux in the completion cycle.

## Interface
- `WIDTH`, default 32: operand/result width; the iteration count equals `WIDTH`.
- `clk`  in  1  : rising-edge clock, the single clock of the block.
- `reset`  in  1  : asynchronous, active-high reset.
- `start`  in  1  : the decoded instruction is an M-op; sampled only in IDLE.
- `abort`  in  1  : synchronous cancel of an in-flight operation.
- `op`  in  2  : 00 mul, 01 divu, 10 remu, 11 reserved.
- `a`  in  WIDTH  : rs1 value (multiplicand or dividend).
- `b`  in  WIDTH  : rs2 value (multiplier or divisor).
- `busy`  out  1  : state is BUSY.
- `done`  out  1  : one-cycle pulse; `result` is valid.
- `stall`  out  1  : hold PC and suppress RegWrite.
- `result`  out  WIDTH  : product low word, quotient or remainder.

## Operation
- States are IDLE, BUSY and DONE. Registered outputs reset to: state IDLE, `busy` 0, `done` 0, `result` 0, counter 0. `stall` is forced to 0 while `reset` is high.
- **IDLE with `start`=1:**
  - Latch `a`, `b` and `op`.
  - Clear the accumulator/remainder.
  - Set counter 0.
  - Go to BUSY.
- **BUSY:** one iteration per cycle, with the counter incrementing.
  - mul: if multiplier LSB is set, acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1. Bits above WIDTH are discarded.
  - divu/remu: restoring division on a (WIDTH+1)-bit remainder. Shift in the next dividend MSB, trial-subtract the divisor, and on no borrow keep the difference and shift in quotient bit 1, else 0.
- **BUSY exit:** when the counter reaches WIDTH-1, the iteration completes, `result` is loaded per `op`, and the state goes to DONE.
- **DONE:**
  - `done`=1 for exactly one cycle, with `stall`=0 so the core commits `result` at this edge.
  - Go to IDLE unconditionally. `start` is ignored in DONE.
- **`result` hold:** `result` holds its value until the next operation completes.
- **Divide by zero:** no special path. Restoring division naturally yields quotient all-ones and remainder = `a`, which matches RISC-V semantics.
- **op 11:** runs the full latency and returns 0.
- **`abort`** has priority over iteration. In BUSY or DONE it forces IDLE next cycle with `done` 0; `result` is unchanged. In IDLE it blocks acceptance of `start`.
- **Reset mid-operation:** immediate IDLE. No `done` pulse is produced and the partial result is discarded.

## Timing
- **Cycle 0:** IDLE with `start`=1 sampled. `stall`=1 combinationally (`start` & IDLE).
- **Cycles 1 to WIDTH:** BUSY, `busy`=1, `stall`=1.
- **Cycle WIDTH+1:** DONE, `done`=1, `stall`=0, `result` valid.
- **Total stall:** WIDTH+1 cycles (33 at the default).
- **Back-to-back:** the earliest next accept is cycle WIDTH+2.
- **Stall equation:** `stall` = (IDLE & `start` & ~`abort`) | BUSY.
- Inputs `a`, `b` and `op` may change after cycle 0 without effect.

## Structure
- **Package `muldiv_pkg`:**
  - `op_t` enum: MUL, DIVU, REMU, RSVD.
  - `state_t` enum: IDLE, BUSY, DONE.
  - ITER_W = $clog2(WIDTH).
- **Sub-module `muldiv_step`:** combinational single iteration. It takes the operand registers plus `op` and returns the next register values. It is unit-testable stand-alone.
- **Top-level contents:** the FSM, the counter and the registers.

## Test plan
- mul: a=7, b=6 -> `done` at cycle 33, `result`=42, `stall` high in cycles 0–32.
- mul: a=0xFFFFFFFF, b=0xFFFFFFFF -> `result`=0x00000001. mul 0x10000 × 0x10000 -> 0x00000000.
- divu 100/7 -> 14; remu 100/7 -> 2; divu 0x80000000/1 -> 0x80000000.
- divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5. Latency is still 33.
- abort in BUSY cycle 10 -> IDLE at cycle 11, no `done`, `result` retains its prior value. A start in cycle 12 is accepted.
- reset asserted mid-BUSY -> outputs 0 asynchronously. With `start` held 1 through DONE, no restart occurs in DONE; a new accept happens in the following IDLE cycle.
